// File: rtl/keyscan_evq.sv
// keyscan_evq
//   Debounces the 4x12 key matrix (48 keys) from per-row column samples
//   delivered by the matrix scanner. Every debounced press/release is turned
//   into an event word and queued in a FIFO. Firmware drains the FIFO over a
//   Wishbone slave port. A level IRQ is raised while events are pending.
//
// Ports
//   clk_24m   in   system clock
//   rst       in   asynchronous, active-high reset
//   scan_row  in   [1:0]  row index of the current sample
//   scan_col  in   [11:0] column sample, 1 = key closed
//   scan_stb  in   one-cycle strobe qualifying scan_row/scan_col
//   wb_addr   in   [1:0]  register word address (0 EVENT, 1 STATUS, 2 CTRL, 3 DEB)
//   wb_wdata  in   [31:0] write data
//   wb_we     in   write enable
//   wb_cyc    in   cycle/strobe
//   wb_rdata  out  [31:0] read data, valid with wb_ack, 0 otherwise
//   wb_ack    out  acknowledge, one wait state, one ack per access
//   irq       out  registered event-pending interrupt
//
// Configuration
//   KEYEVQ_TIMESTAMP_EN : when defined, a free-running millisecond counter
//   (24000-cycle prescaler) is stamped into EVENT[27:12] at push time.
//   When undefined those bits are 0 and the counter logic is absent.

module keyscan_evq #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEB_W       = 4,
  parameter int DEB_DEFAULT = 5
) (
  input  logic        clk_24m,
  input  logic        rst,
  input  logic [1:0]  scan_row,
  input  logic [11:0] scan_col,
  input  logic        scan_stb,
  input  logic [1:0]  wb_addr,
  input  logic [31:0] wb_wdata,
  input  logic        wb_we,
  input  logic        wb_cyc,
  output logic [31:0] wb_rdata,
  output logic        wb_ack,
  output logic        irq
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int NKEYS = 48;

  typedef enum logic {IDLE, WALK} state_t;

  state_t             state_q, state_d;
  logic [1:0]         row_q, row_d;
  logic [11:0]        cols_q, cols_d;
  logic [3:0]         col_q, col_d;
  logic [NKEYS-1:0]   stable_q, stable_d;
  logic [DEB_W-1:0]   cnt_q [NKEYS];
  logic [DEB_W-1:0]   cnt_d [NKEYS];
  logic [31:0]        fifo_q [FIFO_DEPTH];
  logic [31:0]        fifo_d [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               enable_q, enable_d, irq_en_q, irq_en_d;
  logic               ovf_q, ovf_d, overrun_q, overrun_d;
  logic [DEB_W-1:0]   thresh_q, thresh_d;
  logic               wb_ack_q, wb_ack_d;
  logic [31:0]        wb_rdata_q, wb_rdata_d;
  logic               irq_q, irq_d;

  logic               pop, push, push_ok, flush;
  logic [31:0]        ev_word;
  logic [5:0]         key_idx;
  logic               sample;
  logic [DEB_W:0]     cnt_inc;
  logic [31:0]        count_ext;
  logic [7:0]         level;
  logic [15:0]        ts_now;
  logic               unused_wdata;

  assign key_idx   = 6'(row_q) * 6'd12 + 6'(col_q);
  assign sample    = cols_q[col_q];
  assign cnt_inc   = {1'b0, cnt_q[key_idx]} + (DEB_W+1)'(1);
  assign count_ext = 32'(count_q);
  // STATUS level field is 8 bits wide; deeper FIFOs saturate it.
  assign level     = (count_ext > 32'd255) ? 8'hFF : count_ext[7:0];
  assign unused_wdata = ^wb_wdata;

`ifdef KEYEVQ_TIMESTAMP_EN
  logic [14:0] presc_q, presc_d;
  logic [15:0] ms_q, ms_d;

  // Millisecond time base: 24000 cycles of the 24 MHz clock per tick.
  always_comb begin
    presc_d = presc_q + 15'd1;
    ms_d    = ms_q;
    if (presc_q == 15'd23999) begin
      presc_d = '0;
      ms_d    = ms_q + 16'd1;
    end
  end

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      ms_q    <= '0;
    end else begin
      presc_q <= presc_d;
      ms_q    <= ms_d;
    end
  end

  assign ts_now = ms_q;
`else
  assign ts_now = 16'd0;
`endif

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cols_d     = cols_q;
    col_d      = col_q;
    stable_d   = stable_q;
    cnt_d      = cnt_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    ovf_d      = ovf_q;
    overrun_d  = overrun_q;
    thresh_d   = thresh_q;
    wb_ack_d   = wb_cyc & ~wb_ack_q;
    wb_rdata_d = '0;
    irq_d      = irq_en_q & (count_q != '0);
    pop        = 1'b0;
    push       = 1'b0;
    push_ok    = 1'b0;
    flush      = 1'b0;
    ev_word    = '0;

    // Register access is performed on the edge that raises wb_ack, so the
    // returned data, pops and writes all line up with the single ack.
    if (wb_ack_d) begin
      case (wb_addr)
        2'd0: begin
          if (!wb_we && count_q != '0) begin
            wb_rdata_d = fifo_q[rd_ptr_q];
            pop        = 1'b1;
          end
        end
        2'd1: begin
          wb_rdata_d = {16'd0, level, 6'd0, overrun_q, ovf_q};
          if (wb_we) begin
            ovf_d     = ovf_q & ~wb_wdata[0];
            overrun_d = overrun_q & ~wb_wdata[1];
          end
        end
        2'd2: begin
          wb_rdata_d = {30'd0, irq_en_q, enable_q};
          if (wb_we) begin
            enable_d = wb_wdata[0];
            irq_en_d = wb_wdata[1];
            flush    = wb_wdata[2];
          end
        end
        default: begin
          wb_rdata_d = 32'(thresh_q);
          if (wb_we) begin
            thresh_d = (wb_wdata[DEB_W-1:0] == '0) ? DEB_W'(1) : wb_wdata[DEB_W-1:0];
          end
        end
      endcase
    end

    // Row walk: one key per cycle after the strobe is latched.
    case (state_q)
      IDLE: begin
        if (scan_stb && enable_q) begin
          row_d   = scan_row;
          cols_d  = scan_col;
          col_d   = '0;
          state_d = WALK;
        end
      end
      default: begin
        if (scan_stb && enable_q) begin
          overrun_d = 1'b1;
        end
        if (sample == stable_q[key_idx]) begin
          cnt_d[key_idx] = '0;
        end else if (cnt_inc >= {1'b0, thresh_q}) begin
          stable_d[key_idx] = sample;
          cnt_d[key_idx]    = '0;
          push              = 1'b1;
          ev_word           = {1'b1, 3'b000, ts_now, 3'b000, sample, 2'b00, key_idx};
        end else begin
          cnt_d[key_idx] = cnt_inc[DEB_W-1:0];
        end
        if (col_q == 4'd11) begin
          col_d   = '0;
          state_d = IDLE;
        end else begin
          col_d = col_q + 4'd1;
        end
      end
    endcase

    // Disabling abandons partial debounce progress but keeps stable bits.
    if (enable_q && !enable_d) begin
      for (int i = 0; i < NKEYS; i++) begin
        cnt_d[i] = '0;
      end
      state_d = IDLE;
    end

    // A pop frees a slot in the same cycle, so push+pop works even when full.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      push_ok = push && ((count_q != CW'(FIFO_DEPTH)) || pop);
      if (push && !push_ok) begin
        ovf_d = 1'b1;
      end
      if (push_ok) begin
        fifo_d[wr_ptr_q] = ev_word;
        wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop);
    end
  end

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      cols_q     <= '0;
      col_q      <= '0;
      stable_q   <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        cnt_q[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
      overrun_q  <= 1'b0;
      thresh_q   <= DEB_W'(DEB_DEFAULT);
      wb_ack_q   <= 1'b0;
      wb_rdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cols_q     <= cols_d;
      col_q      <= col_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      ovf_q      <= ovf_d;
      overrun_q  <= overrun_d;
      thresh_q   <= thresh_d;
      wb_ack_q   <= wb_ack_d;
      wb_rdata_q <= wb_rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign wb_ack   = wb_ack_q;
  assign wb_rdata = wb_rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_keyscan_evq.sv
// tb_keyscan_evq
//   Drives keyscan_evq with scan rows and Wishbone accesses, and predicts
//   every register/event value from a row-level model of the debounce and
//   event queue rules (a key changes state after `threshold` consecutive
//   differing samples; events queue up to 16 deep).

module tb_keyscan_evq;

  logic        clk_24m = 1'b0;
  logic        rst;
  logic [1:0]  scan_row;
  logic [11:0] scan_col;
  logic        scan_stb;
  logic [1:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic        wb_cyc;
  logic [31:0] wb_rdata;
  logic        wb_ack;
  logic        irq;

  int checks = 0;
  int errors = 0;

`ifdef KEYEVQ_TIMESTAMP_EN
  localparam logic [31:0] EV_MASK = 32'hF000_0FFF;
`else
  localparam logic [31:0] EV_MASK = 32'hFFFF_FFFF;
`endif

  // Reference model state
  bit          m_stable [48];
  int          m_cnt [48];
  int          m_thresh;
  bit          m_en;
  bit          m_ovf;
  bit          m_overrun;
  logic [31:0] m_q [$];
  logic [11:0] last_pat [4];

  keyscan_evq dut (
    .clk_24m (clk_24m),
    .rst     (rst),
    .scan_row(scan_row),
    .scan_col(scan_col),
    .scan_stb(scan_stb),
    .wb_addr (wb_addr),
    .wb_wdata(wb_wdata),
    .wb_we   (wb_we),
    .wb_cyc  (wb_cyc),
    .wb_rdata(wb_rdata),
    .wb_ack  (wb_ack),
    .irq     (irq)
  );

  always #20 clk_24m = ~clk_24m;

  function automatic logic [31:0] m_status();
    return {16'd0, 8'(m_q.size()), 6'd0, m_overrun, m_ovf};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 48; k++) begin
      m_stable[k] = 1'b0;
      m_cnt[k]    = 0;
    end
    m_thresh  = 5;
    m_en      = 1'b0;
    m_ovf     = 1'b0;
    m_overrun = 1'b0;
    m_q.delete();
  endtask

  // Whole-row debounce update, applied once the DUT has walked the row.
  task automatic model_scan(input int row, input logic [11:0] cols);
    for (int c = 0; c < 12; c++) begin
      int k;
      bit s;
      k = row * 12 + c;
      s = cols[c];
      if (s == m_stable[k]) begin
        m_cnt[k] = 0;
      end else if (m_cnt[k] + 1 >= m_thresh) begin
        m_stable[k] = s;
        m_cnt[k]    = 0;
        if (m_q.size() < 16) m_q.push_back(32'h8000_0000 | (32'(s) << 8) | 32'(k));
        else m_ovf = 1'b1;
      end else begin
        m_cnt[k]++;
      end
    end
  endtask

  task automatic wb_access(input logic [1:0] a, input logic we, input logic [31:0] wd,
                           output logic [31:0] rd);
    bit got;
    got = 0;
    rd  = '0;
    @(negedge clk_24m);
    wb_cyc = 1'b1; wb_addr = a; wb_we = we; wb_wdata = wd;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk_24m); #1;
      if (wb_ack) begin
        rd  = wb_rdata;
        got = 1;
      end
    end
    @(negedge clk_24m);
    wb_cyc = 1'b0; wb_we = 1'b0;
    if (!got) begin
      errors++;
      $display("[TB] FAIL wb_ack_timeout addr %0d: no ack within 4 cycles, required ack", a);
    end
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    wb_access(a, 1'b0, 32'd0, d);
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_access(a, 1'b1, d, dummy);
  endtask

  task automatic ctrl_write(input logic [31:0] v);
    wb_write(2'd2, v);
    if (m_en && !v[0]) for (int k = 0; k < 48; k++) m_cnt[k] = 0;
    m_en = v[0];
    if (v[2]) m_q.delete();
  endtask

  task automatic deb_write(input logic [31:0] v);
    wb_write(2'd3, v);
    m_thresh = (v[3:0] == 4'd0) ? 1 : int'(v[3:0]);
  endtask

  task automatic status_clear(input logic [31:0] v);
    wb_write(2'd1, v);
    if (v[0]) m_ovf = 1'b0;
    if (v[1]) m_overrun = 1'b0;
  endtask

  task automatic do_scan(input int row, input logic [11:0] cols);
    @(negedge clk_24m);
    scan_stb = 1'b1; scan_row = 2'(row); scan_col = cols;
    @(negedge clk_24m);
    scan_stb = 1'b0;
    repeat (14) @(negedge clk_24m);
    if (m_en) model_scan(row, cols);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk_24m);
    checks++; if (wb_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack got %b exp 0", wb_ack); end
    checks++; if (wb_rdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_rdata got %h exp 0", wb_rdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq got %b exp 0", irq); end
    rst = 1'b0;
    model_reset();
    wb_read(2'd1, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL reset_status got %h exp 0", d); end
    wb_read(2'd2, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL reset_ctrl got %h exp 0", d); end
    wb_read(2'd3, d);
    checks++; if (d !== 32'd5) begin errors++; $display("[TB] FAIL reset_deb got %h exp 5", d); end
    wb_read(2'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL reset_event got %h exp 0", d); end
  endtask

  task automatic test_basic_press();
    logic [31:0] d;
    logic [31:0] exp;
    ctrl_write(32'd1);
    deb_write(32'd3);
    repeat (3) do_scan(1, 12'h010);
    exp = (m_q.size() > 0) ? m_q.pop_front() : 32'd0;
    checks++; if (exp !== 32'h8000_0110) begin errors++; $display("[TB] FAIL basic_model got %h exp 80000110", exp); end
    wb_read(2'd0, d);
    checks++; if ((d & EV_MASK) !== 32'h8000_0110) begin errors++; $display("[TB] FAIL basic_event got %h exp 80000110", d); end
    wb_read(2'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL basic_empty got %h exp 0", d); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    do_scan(1, 12'h030);
    do_scan(1, 12'h030);
    do_scan(1, 12'h010);
    wb_read(2'd1, d);
    checks++; if (d !== 32'd0 || d !== m_status()) begin errors++; $display("[TB] FAIL glitch_status got %h exp 0", d); end
  endtask

  task automatic test_disable();
    logic [31:0] d;
    do_scan(1, 12'h030);
    do_scan(1, 12'h030);
    ctrl_write(32'd0);
    do_scan(1, 12'h030);
    ctrl_write(32'd1);
    do_scan(1, 12'h030);
    wb_read(2'd1, d);
    checks++; if (d !== m_status() || d !== 32'd0) begin errors++; $display("[TB] FAIL disable_status got %h exp %h", d, m_status()); end
    do_scan(1, 12'h030);
    do_scan(1, 12'h030);
    wb_read(2'd0, d);
    checks++; if ((d & EV_MASK) !== 32'h8000_0111 || m_q.size() != 1) begin errors++; $display("[TB] FAIL disable_event got %h exp 80000111", d); end
    void'(m_q.pop_front());
  endtask

  task automatic test_flush_deb();
    logic [31:0] d;
    deb_write(32'd0);
    wb_read(2'd3, d);
    checks++; if (d !== 32'd1) begin errors++; $display("[TB] FAIL deb_zero got %h exp 1", d); end
    do_scan(3, 12'hFFF);
    wb_read(2'd1, d);
    checks++; if (d !== m_status() || d[15:8] !== 8'd12) begin errors++; $display("[TB] FAIL flush_pre_level got %h exp %h", d, m_status()); end
    ctrl_write(32'd5);
    wb_read(2'd1, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL flush_level got %h exp 0", d); end
    wb_read(2'd2, d);
    checks++; if (d !== 32'd1) begin errors++; $display("[TB] FAIL flush_ctrl got %h exp 1", d); end
    wb_read(2'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL flush_event got %h exp 0", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [31:0] exp;
    for (int r = 0; r < 4; r++) do_scan(r, 12'h000);
    ctrl_write(32'd5);
    status_clear(32'd3);
    do_scan(0, 12'hFFF);
    do_scan(1, 12'h01F);
    wb_read(2'd1, d);
    checks++; if (d !== 32'h0000_1001 || d !== m_status()) begin errors++; $display("[TB] FAIL ovf_status got %h exp 00001001", d); end
    status_clear(32'd1);
    wb_read(2'd1, d);
    checks++; if (d !== 32'h0000_1000) begin errors++; $display("[TB] FAIL ovf_clear got %h exp 00001000", d); end
    for (int i = 0; i < 16; i++) begin
      exp = (m_q.size() > 0) ? m_q.pop_front() : 32'd0;
      wb_read(2'd0, d);
      checks++; if ((d & EV_MASK) !== exp) begin errors++; $display("[TB] FAIL ovf_pop%0d got %h exp %h", i, d, exp); end
    end
    wb_read(2'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL ovf_empty got %h exp 0", d); end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    logic [31:0] exp;
    status_clear(32'd3);
    @(negedge clk_24m);
    scan_stb = 1'b1; scan_row = 2'd2; scan_col = 12'h00F;
    @(negedge clk_24m);
    scan_stb = 1'b0;
    repeat (3) @(negedge clk_24m);
    scan_stb = 1'b1; scan_row = 2'd2; scan_col = 12'hFF0;
    @(negedge clk_24m);
    scan_stb = 1'b0;
    repeat (14) @(negedge clk_24m);
    model_scan(2, 12'h00F);
    m_overrun = 1'b1;
    wb_read(2'd1, d);
    checks++; if (d !== m_status() || d !== 32'h0000_0402) begin errors++; $display("[TB] FAIL overrun_status got %h exp %h", d, m_status()); end
    while (m_q.size() > 0) begin
      exp = m_q.pop_front();
      wb_read(2'd0, d);
      checks++; if ((d & EV_MASK) !== exp) begin errors++; $display("[TB] FAIL overrun_event got %h exp %h", d, exp); end
    end
    status_clear(32'd3);
  endtask

  task automatic test_push_pop_full();
    logic [31:0] d;
    logic [31:0] exp;
    do_scan(3, 12'hFFF);
    do_scan(2, 12'h000);
    wb_read(2'd1, d);
    checks++; if (d !== m_status() || d[15:8] !== 8'd16) begin errors++; $display("[TB] FAIL full_level got %h exp %h", d, m_status()); end
    // Strobe, then start a read so the pop and col-0 push hit the same edge.
    @(negedge clk_24m);
    scan_stb = 1'b1; scan_row = 2'd3; scan_col = 12'hFFE;
    @(negedge clk_24m);
    scan_stb = 1'b0; wb_cyc = 1'b1; wb_addr = 2'd0; wb_we = 1'b0;
    @(posedge clk_24m); #1;
    exp = m_q.pop_front();
    checks++; if (wb_ack !== 1'b1 || (wb_rdata & EV_MASK) !== exp) begin errors++; $display("[TB] FAIL pushpop_read got ack %b data %h exp ack 1 data %h", wb_ack, wb_rdata, exp); end
    @(negedge clk_24m);
    wb_cyc = 1'b0;
    repeat (14) @(negedge clk_24m);
    model_scan(3, 12'hFFE);
    wb_read(2'd1, d);
    checks++; if (d !== m_status() || d !== 32'h0000_1000) begin errors++; $display("[TB] FAIL pushpop_status got %h exp 00001000", d); end
    while (m_q.size() > 0) begin
      exp = m_q.pop_front();
      wb_read(2'd0, d);
      checks++; if ((d & EV_MASK) !== exp) begin errors++; $display("[TB] FAIL pushpop_drain got %h exp %h", d, exp); end
    end
  endtask

  task automatic test_irq();
    logic [31:0] exp;
    ctrl_write(32'd3);
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_idle got %b exp 0", irq); end
    @(negedge clk_24m);
    scan_stb = 1'b1; scan_row = 2'd3; scan_col = 12'hFFF;
    @(negedge clk_24m);
    scan_stb = 1'b0;
    @(posedge clk_24m); #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_push_edge got %b exp 0", irq); end
    @(posedge clk_24m); #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_after_push got %b exp 1", irq); end
    repeat (14) @(negedge clk_24m);
    model_scan(3, 12'hFFF);
    wb_cyc = 1'b1; wb_addr = 2'd0; wb_we = 1'b0;
    @(posedge clk_24m); #1;
    exp = (m_q.size() > 0) ? m_q.pop_front() : 32'd0;
    checks++; if ((wb_rdata & EV_MASK) !== exp || irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_pop_ack got data %h irq %b exp data %h irq 1", wb_rdata, irq, exp); end
    @(negedge clk_24m);
    wb_cyc = 1'b0;
    @(posedge clk_24m); #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_after_pop got %b exp 0", irq); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] exp;
    int row;
    int npop;
    ctrl_write(32'd1);
    for (int r = 0; r < 4; r++) last_pat[r] = 12'h000;
    for (int it = 0; it < 40; it++) begin
      if (it % 10 == 0) deb_write(32'($urandom_range(1, 3)));
      row = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) last_pat[row] = 12'($urandom);
      do_scan(row, last_pat[row]);
      if (it % 5 == 4) begin
        wb_read(2'd1, d);
        checks++; if (d !== m_status()) begin errors++; $display("[TB] FAIL rand_status it%0d got %h exp %h", it, d, m_status()); end
        npop = $urandom_range(0, m_q.size());
        for (int i = 0; i < npop; i++) begin
          exp = m_q.pop_front();
          wb_read(2'd0, d);
          checks++; if ((d & EV_MASK) !== exp) begin errors++; $display("[TB] FAIL rand_event it%0d got %h exp %h", it, d, exp); end
        end
      end
    end
    while (m_q.size() > 0) begin
      exp = m_q.pop_front();
      wb_read(2'd0, d);
      checks++; if ((d & EV_MASK) !== exp) begin errors++; $display("[TB] FAIL rand_drain got %h exp %h", d, exp); end
    end
    wb_read(2'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL rand_empty got %h exp 0", d); end
    status_clear(32'd3);
  endtask

  task automatic test_reset_midwalk();
    logic [31:0] d;
    ctrl_write(32'd3);
    do_scan(0, 12'h000);
    @(negedge clk_24m);
    scan_stb = 1'b1; scan_row = 2'd1; scan_col = 12'hFFF;
    @(negedge clk_24m);
    scan_stb = 1'b0;
    repeat (3) @(negedge clk_24m);
    rst = 1'b1;
    #1;
    checks++; if (irq !== 1'b0 || wb_ack !== 1'b0) begin errors++; $display("[TB] FAIL midwalk_async got irq %b ack %b exp 0 0", irq, wb_ack); end
    repeat (2) @(negedge clk_24m);
    rst = 1'b0;
    model_reset();
    repeat (14) @(negedge clk_24m);
    wb_read(2'd1, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL midwalk_status got %h exp 0", d); end
    wb_read(2'd2, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL midwalk_ctrl got %h exp 0", d); end
    wb_read(2'd3, d);
    checks++; if (d !== 32'd5) begin errors++; $display("[TB] FAIL midwalk_deb got %h exp 5", d); end
    wb_read(2'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL midwalk_event got %h exp 0", d); end
  endtask

  initial begin
    rst      = 1'b1;
    scan_row = '0;
    scan_col = '0;
    scan_stb = 1'b0;
    wb_addr  = '0;
    wb_wdata = '0;
    wb_we    = 1'b0;
    wb_cyc   = 1'b0;
    test_reset();
    test_basic_press();
    test_glitch();
    test_disable();
    test_flush_deb();
    test_overflow();
    test_overrun();
    test_push_pop_full();
    test_irq();
    test_random();
    test_reset_midwalk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
